// File: rtl/mod_ram_arb_pkg.sv
// Shared types and constants for the two-master block-RAM data-port arbiter.
// Holds the FSM state encoding, the one-hot grant codes and the default parameters.
package mod_ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int DEF_ADDR_BITS = 11;
    localparam int DEF_RAM_LAT   = 1;

    // Wide enough for RAM_LAT-1 with RAM_LAT up to 4.
    localparam int CNT_W = 2;

    function automatic logic addr_out_of_range(input logic [31:0] addr, input int abits);
        return (addr >> (abits + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/mod_ram_arb_rr.sv
// Combinational two-way round-robin picker with an m1 priority hold.
// Produces a one-hot pick, or GNT_NONE when nobody requests.
module mod_ram_arb_rr
    import mod_ram_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] last_grant,
    input  logic       lock,
    output logic [1:0] pick
);

    always_comb begin
        pick = GNT_NONE;
        if (lock && req1) begin
            pick = GNT_M1;
        end else if (req0 && !req1) begin
            pick = GNT_M0;
        end else if (req1 && !req0) begin
            pick = GNT_M1;
        end else if (req0 && req1) begin
            pick = (last_grant == GNT_M0) ? GNT_M1 : GNT_M0;
        end
    end

endmodule

// File: rtl/mod_ram_arbiter.sv
// Shares the block-RAM data port between two req/ack bus masters.
// Round-robin with optional m1 lock; out-of-range addresses never strobe the RAM.
module mod_ram_arbiter
    import mod_ram_arb_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int RAM_LAT   = DEF_RAM_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    input  logic        m1_lock,
    output logic        ram_de,
    output logic        ram_drw,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic [1:0]  grant,
    output logic        busy
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [1:0]         r_grant;
    logic [1:0]         r_last_grant;
    logic               r_lock;
    logic               r_err;
    logic               r_ram_de;
    logic               r_ram_drw;
    logic               r_m0_ack;
    logic               r_m1_ack;
    logic               r_m0_err;
    logic               r_m1_err;
    logic [31:0]        r_m0_rdata;
    logic [31:0]        r_m1_rdata;

    logic [1:0]         w_pick;
    logic               w_sel_we;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic               w_sel_oor;

    mod_ram_arb_rr u_rr (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_grant (r_last_grant),
        .lock       (r_lock),
        .pick       (w_pick)
    );

    assign w_sel_we    = (w_pick == GNT_M1) ? m1_we    : m0_we;
    assign w_sel_addr  = (w_pick == GNT_M1) ? m1_addr  : m0_addr;
    assign w_sel_wdata = (w_pick == GNT_M1) ? m1_wdata : m0_wdata;
    assign w_sel_oor   = addr_out_of_range(w_sel_addr, ADDR_BITS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_grant      <= GNT_NONE;
            r_last_grant <= GNT_M1;
            r_lock       <= 1'b0;
            r_err        <= 1'b0;
            r_ram_de     <= 1'b0;
            r_ram_drw    <= 1'b0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            r_m0_err <= 1'b0;
            r_m1_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick != GNT_NONE) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr & 32'hFFFF_FFFC;
                        r_wdata      <= w_sel_wdata;
                        r_err        <= w_sel_oor;
                        if (w_sel_oor) begin
                            // Rejected request skips ACCESS; ack and err land together in DONE.
                            r_state  <= ST_DONE;
                            r_m0_ack <= (w_pick == GNT_M0);
                            r_m1_ack <= (w_pick == GNT_M1);
                            r_m0_err <= (w_pick == GNT_M0);
                            r_m1_err <= (w_pick == GNT_M1);
                        end else begin
                            r_state   <= ST_ACCESS;
                            r_cnt     <= CNT_W'(RAM_LAT - 1);
                            r_ram_de  <= 1'b1;
                            r_ram_drw <= w_sel_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state   <= ST_DONE;
                        r_ram_de  <= 1'b0;
                        r_ram_drw <= 1'b0;
                        r_m0_ack  <= (r_grant == GNT_M0);
                        r_m1_ack  <= (r_grant == GNT_M1);
                        if (!r_we && r_grant == GNT_M0) begin
                            r_m0_rdata <= ram_dout;
                        end
                        if (!r_we && r_grant == GNT_M1) begin
                            r_m1_rdata <= ram_dout;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_grant <= GNT_NONE;
                    r_err   <= 1'b0;
                    r_lock  <= m1_lock && (r_grant == GNT_M1);
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_ack   = r_m0_ack;
    assign m1_ack   = r_m1_ack;
    assign m0_err   = r_m0_err;
    assign m1_err   = r_m1_err;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign ram_de   = r_ram_de;
    assign ram_drw  = r_ram_drw;
    assign ram_addr = r_addr;
    assign ram_din  = r_wdata;
    assign grant    = r_grant;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: doc/mod_ram_arbiter.md
Name: mod_ram_arbiter

Overview:
Shares the data port of the on-chip block RAM between two bus masters: m0 (CPU data path) and m1 (bootloader/debug DMA that loads programs over UART). It uses round-robin arbitration, with an optional m1 lock for back-to-back bursts. Each transaction uses a req/ack handshake, and each master gets a registered read-data return. Out-of-range addresses are rejected before any RAM strobe. It sits between the masters and the RAM data port (de/drw/daddr/din/dout); the instruction port is untouched.

Parameters:
ADDR_BITS, 11, RAM word-address width; RAM byte span = 4 << ADDR_BITS (8 KB).
RAM_LAT, 1, cycles from RAM strobe to valid ram_dout (1..4).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst==0 resets on rising clk)
m0_req  in  1  m0 request; hold with addr/we/wdata stable until m0_ack
m0_we  in  1  1 = write, 0 = read
m0_addr  in  32  byte address, word aligned (bits[1:0] ignored)
m0_wdata  in  32  write data
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  valid with m0_ack; 1 = address out of range
m0_rdata  out  32  read data, valid in m0_ack cycle, held until next m0 ack
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  (same as m0)
m1_lock  in  1  when high at m1 completion, m1 keeps priority next arbitration
ram_de  out  1  RAM data-port enable
ram_drw  out  1  RAM write strobe (only with ram_de)
ram_addr  out  32  byte address to RAM (bits[1:0] forced 0)
ram_din  out  32  RAM write data
ram_dout  in  32  RAM read data
grant  out  2  one-hot owner of current transaction (00 idle)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at clk edge): state=IDLE, all outputs 0, rdata regs 0, last_grant=m1 (m0 wins first tie), lock flag cleared, latency counter 0. Applies mid-transaction: no ack issued, ram_de drops at that edge, and a write in progress may or may not complete.
- FSM: IDLE, ACCESS, DONE.
- IDLE: no req -> stay. Otherwise pick winner:
  - if lock flag set and m1_req -> m1;
  - else if exactly one req -> that master;
  - else both req -> master != last_grant.
- IDLE capture: latch winner's addr/we/wdata into internal regs and set grant and last_grant.
- IDLE range check: addr[31:ADDR_BITS+2] != 0 -> go to DONE with err=1, no RAM strobe. Else -> ACCESS with counter=RAM_LAT-1.
- ACCESS: ram_de=1, ram_drw=latched we, ram_addr/ram_din from latched regs (registered outputs, stable for the whole state).
  - Counter decrements each cycle; at 0 -> DONE.
  - For reads, ram_dout is captured into the winner's rdata reg on the last ACCESS cycle.
  - The other master's rdata is untouched.
- DONE: winner's ack=1 for exactly one cycle, err as determined, ram_de=0.
  - Lock flag := m1_lock && grant==m1.
  - Next state IDLE; grant clears.
- Latency, req seen in IDLE to ack: RAM_LAT+2 cycles; error path 2 cycles. Throughput: one transaction per RAM_LAT+2 cycles.
- A req still high in the IDLE cycle after ack is a new transaction; masters must drop req in the cycle after ack to avoid a repeat.
- Req dropped before ack is a protocol violation: the transaction still completes (write still lands) and the ack is still pulsed.
- Writes with err=1 never reach RAM. Reads with err=1 return rdata unchanged.
- m0_ack and m1_ack are never high together. ram_drw is never high without ram_de.

Decomposition:
- Shared package mod_ram_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), grant codes (GNT_NONE, GNT_M0, GNT_M1), default ADDR_BITS and RAM_LAT.
- One sub-module, mod_ram_arb_rr: combinational two-way round-robin picker (inputs req0, req1, last_grant, lock; output one-hot pick).

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then 1 with no reqs -> all outputs 0, busy=0, grant=00 indefinitely.
- Single write/read (RAM_LAT=1): m0 write addr 0x10 data 0xDEADBEEF, then read 0x10 -> ram_de high 1 cycle per access, ram_drw=1 only on write, m0_ack 3 cycles after req, m0_rdata=0xDEADBEEF, m0_err=0.
- Simultaneous requests: m0 and m1 both read from reset, both re-requesting after each ack -> grants alternate m0, m1, m0, m1; never two acks in one cycle.
- Lock burst: m1_lock=1, m1 writes 4 words 0x100..0x10C while m0_req held high -> all 4 m1 acks before m0. Then drop lock -> m0 granted next.
- Range error: m1 write addr 0x00002000 (ADDR_BITS=11) -> m1_ack with m1_err=1 2 cycles after req, ram_de never asserted; reading 0x0 afterward shows prior contents unchanged.
- Reset mid-access: RAM_LAT=3, assert rst=0 during ACCESS -> no ack, state IDLE next cycle, ram_de=0; a fresh m0 read after release completes normally.
